jtag_unlock_ctrl: RTL
=====================

// Module: jtag_unlock_ctrl
// PURPOSE
//   Password-gated JTAG unlock controller. Directly upstream of the register-lock block.
//   Drives that block's jtag_unlock input.
//   Debugger writes a PWD_WORDS x 32-bit password word-serially over a valid/ready port.
//   Each word is compared on the fly against fuse_pwd_i.
//   A match raises jtag_unlock_o until relock_i is asserted.
//   MAX_ATTEMPTS consecutive failures enforce a LOCKOUT_CYCLES lockout.
// PARAMETERS
//   PWD_WORDS       4     number of 32-bit password words (>=1)
//   MAX_ATTEMPTS    3     consecutive failures that trigger lockout (>=1)
//   LOCKOUT_CYCLES  1024  lockout duration in clk_i cycles (>=1)
// PORTS
//   clk_i          in   1               single clock
//   rst_ni         in   1               asynchronous, active-low reset
//   pwd_valid_i    in   1               password word valid
//   pwd_ready_o    out  1               controller accepts a word
//   pwd_data_i     in   32              password word, word 0 first
//   pwd_last_i     in   1               marks final word of a submission
//   fuse_pwd_i     in   32*PWD_WORDS    reference password; word k = [32k+:32]; static while out of reset
//   relock_i       in   1               drop unlock / abort a partial submission
//   jtag_unlock_o  out  1               unlock grant to register-lock block
//   fail_o         out  1               one-cycle pulse per failed submission
//   lockout_o      out  1               high while in lockout
//   attempts_o     out  $clog2(MAX_ATTEMPTS+1)  consecutive failure count
// BEHAVIOUR
//   Reset (async assert, sync deassert by system)
//   - State IDLE; all outputs 0; word index 0; mismatch flag 0; lockout timer 0.
//   - Reset mid-operation discards any partial submission.
//   - jtag_unlock_o falls immediately on reset assertion.
//   States: IDLE, COLLECT, CHECK, UNLOCKED, LOCKOUT. All outputs are registered.
//   IDLE / COLLECT
//   - pwd_ready_o=1. A word is accepted when pwd_valid_i && pwd_ready_o.
//   - On accept: mismatch |= (pwd_data_i != fuse word[idx]); idx++; IDLE->COLLECT.
//   - Accept with idx==PWD_WORDS-1 or pwd_last_i=1 -> CHECK.
//   - pwd_last_i before PWD_WORDS words forces mismatch=1 (short password fails).
//   - relock_i=1 (takes priority over a same-cycle accept) -> IDLE.
//     Partial submission discarded; attempts unchanged.
//   CHECK (exactly 1 cycle, pwd_ready_o=0)
//   - mismatch==0: -> UNLOCKED, attempts_o<=0.
//   - mismatch==1 and attempts+1 < MAX_ATTEMPTS: attempts++, fail_o pulse, -> IDLE.
//   - mismatch==1 and attempts+1 == MAX_ATTEMPTS: attempts++, fail_o pulse,
//     timer<=LOCKOUT_CYCLES-1, -> LOCKOUT.
//   - idx and mismatch are cleared on leaving CHECK.
//   Latency
//   - Final word accepted in cycle N: CHECK in N+1.
//   - jtag_unlock_o or fail_o (and lockout_o) high from N+2.
//   - fail_o is high for exactly one cycle.
//   UNLOCKED
//   - pwd_ready_o=0, jtag_unlock_o=1; pwd_valid_i ignored.
//   - relock_i=1 -> IDLE; jtag_unlock_o low from the next cycle.
//   LOCKOUT
//   - pwd_ready_o=0, lockout_o=1; relock_i ignored.
//   - Timer decrements every cycle; at timer==0 -> IDLE with attempts_o<=0.
//   - lockout_o is high for exactly LOCKOUT_CYCLES cycles.
//   attempts_o saturates at MAX_ATTEMPTS and never wraps.
//   attempts_o clears only on successful unlock, lockout expiry or reset.
//   Counter widths: idx $clog2(PWD_WORDS) (min 1 bit); timer $clog2(LOCKOUT_CYCLES) (min 1 bit).
// TESTING
//   1. fuse=128'hA5A5_0001_2222_3333; send 4 matching words, valid held high ->
//      ready low from cycle 5, jtag_unlock_o=1 at cycle 6, attempts_o=0.
//   2. Word 2 wrong, MAX_ATTEMPTS=3 -> fail_o one-cycle pulse, attempts_o=1, back to IDLE,
//      ready=1; then a correct password -> unlock, attempts_o=0.
//   3. Three wrong submissions -> third gives fail_o + lockout_o=1 for exactly 1024 cycles.
//      ready=0 and relock_i ignored throughout; then IDLE, attempts_o=0.
//   4. pwd_last_i on word 1 with correct data -> treated as fail, attempts_o=1.
//   5. Two words sent, then relock_i -> IDLE, attempts_o unchanged.
//      Next full correct password unlocks, showing no stale mismatch.
//   6. While UNLOCKED: relock_i -> unlock low next cycle.
//      Separately, rst_ni low mid-COLLECT -> all outputs 0 immediately.

Source files
------------

// File: rtl/jtag_unlock_ctrl.sv
// Password-gated JTAG unlock controller: word-serial password compare against fuses,
// unlock grant until relock, and a timed lockout after repeated consecutive failures.
module jtag_unlock_ctrl #(
  parameter int unsigned PWD_WORDS      = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pwd_valid_i,
  output logic                               pwd_ready_o,
  input  logic [31:0]                        pwd_data_i,
  input  logic                               pwd_last_i,
  input  logic [32*PWD_WORDS-1:0]            fuse_pwd_i,
  input  logic                               relock_i,
  output logic                               jtag_unlock_o,
  output logic                               fail_o,
  output logic                               lockout_o,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  attempts_o
);

  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned IDX_W = (PWD_WORDS > 1) ? $clog2(PWD_WORDS) : 1;
  localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  logic [2:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             mismatch, mismatch_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [ATT_W-1:0] att_n;
  logic             fail_n;
  logic [31:0]      fuse_word;
  logic [31:0]      att_inc;
  logic             accept;
  logic             is_last_idx;

  always_comb begin
    fuse_word = '0;
    for (int unsigned k = 0; k < PWD_WORDS; k++) begin
      if (idx == IDX_W'(k)) fuse_word = fuse_pwd_i[32*k +: 32];
    end
  end

  assign accept      = pwd_valid_i && pwd_ready_o;
  assign is_last_idx = (idx == IDX_W'(PWD_WORDS - 1));
  assign att_inc     = 32'(attempts_o) + 32'd1;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mismatch_n = mismatch;
    timer_n    = timer;
    att_n      = attempts_o;
    fail_n     = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (relock_i) begin
          state_n    = S_IDLE;
          idx_n      = '0;
          mismatch_n = 1'b0;
        end else if (accept) begin
          // an early last flag can never match, so it poisons the submission
          mismatch_n = mismatch | (pwd_data_i != fuse_word) | (pwd_last_i && !is_last_idx);
          if (is_last_idx || pwd_last_i) begin
            state_n = S_CHECK;
          end else begin
            state_n = S_COLLECT;
            idx_n   = idx + IDX_W'(1);
          end
        end
      end
      S_CHECK: begin
        idx_n      = '0;
        mismatch_n = 1'b0;
        if (!mismatch) begin
          state_n = S_UNLOCKED;
          att_n   = '0;
        end else begin
          fail_n = 1'b1;
          if (att_inc >= 32'(MAX_ATTEMPTS)) begin
            att_n   = ATT_W'(MAX_ATTEMPTS);
            timer_n = TMR_W'(LOCKOUT_CYCLES - 1);
            state_n = S_LOCKOUT;
          end else begin
            att_n   = ATT_W'(att_inc);
            state_n = S_IDLE;
          end
        end
      end
      S_UNLOCKED: begin
        if (relock_i) state_n = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_IDLE;
          att_n   = '0;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      default: begin
        state_n    = S_IDLE;
        idx_n      = '0;
        mismatch_n = 1'b0;
      end
    endcase
  end

  // outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      idx           <= '0;
      mismatch      <= 1'b0;
      timer         <= '0;
      attempts_o    <= '0;
      fail_o        <= 1'b0;
      pwd_ready_o   <= 1'b0;
      jtag_unlock_o <= 1'b0;
      lockout_o     <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      mismatch      <= mismatch_n;
      timer         <= timer_n;
      attempts_o    <= att_n;
      fail_o        <= fail_n;
      pwd_ready_o   <= (state_n == S_IDLE) || (state_n == S_COLLECT);
      jtag_unlock_o <= (state_n == S_UNLOCKED);
      lockout_o     <= (state_n == S_LOCKOUT);
    end
  end

endmodule
